// File: rtl/pixel_out_stage.sv
// Saturating 8-bit pixel packer with frame tracking, output FIFO and status registers.
// Define PIXEL_OUT_STATS_EN to include the FRAME_CNT / LAST_MIN / LAST_MAX statistics.
module pixel_out_stage #(
  parameter int IN_WIDTH   = 32,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic                out_last,
  input  logic                reg_write_en,
  input  logic [4:0]          reg_addr,
  input  logic [7:0]          reg_wdata,
  output logic [7:0]          reg_rdata
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic            ctrl_enable;
  logic            overflow;
  logic [7:0]      drop_cnt;
  logic [1:0]      lane_cnt;
  logic [23:0]     lanes;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [32:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic            accept;
  logic            at_frame_end;
  logic            frame_end;
  logic            word_done;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic            drop;
  logic            ctrl_wr;
  logic [7:0]      sat_pix;
  logic [31:0]     word;
  logic [7:0]      rdata_next;
  logic [7:0]      frame_cnt;
  logic [7:0]      last_min;
  logic [7:0]      last_max;
  logic            unused_wdata;

  assign unused_wdata = ^reg_wdata[7:2];

  always_comb begin
    if (in_pixel[IN_WIDTH-1])             sat_pix = '0;
    else if (|in_pixel[IN_WIDTH-2:8])     sat_pix = '1;
    else                                  sat_pix = in_pixel[7:0];
  end

  // The current pixel completes the word combinationally so it is written at the accepting edge.
  always_comb begin
    case (lane_cnt)
      2'd0:    word = {24'h0, sat_pix};
      2'd1:    word = {16'h0, sat_pix, lanes[7:0]};
      2'd2:    word = {8'h0, sat_pix, lanes[15:0]};
      default: word = {sat_pix, lanes};
    endcase
  end

  assign accept       = in_valid && ctrl_enable;
  assign at_frame_end = (col == COL_LAST) && (row == ROW_LAST);
  assign frame_end    = accept && at_frame_end;
  assign word_done    = (lane_cnt == 2'd3) || at_frame_end;
  assign fifo_full    = (count == CNT_FULL);
  assign fifo_empty   = (count == '0);
  assign pop          = !fifo_empty && out_ready;
  assign push         = accept && word_done && (!fifo_full || pop);
  assign drop         = accept && word_done && fifo_full && !pop;
  assign ctrl_wr      = reg_write_en && (reg_addr == 5'h10);

  always_comb begin
    out_valid = !fifo_empty;
    out_data  = fifo_empty ? '0 : mem[rd_ptr][31:0];
    out_last  = fifo_empty ? 1'b0 : mem[rd_ptr][32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt <= '0;
      lanes    <= '0;
      col      <= '0;
      row      <= '0;
    end else if (accept) begin
      case (lane_cnt)
        2'd0:    lanes[7:0]   <= sat_pix;
        2'd1:    lanes[15:8]  <= sat_pix;
        2'd2:    lanes[23:16] <= sat_pix;
        default: ;
      endcase
      if (at_frame_end) begin
        lane_cnt <= '0;
        col      <= '0;
        row      <= '0;
      end else begin
        lane_cnt <= lane_cnt + 2'd1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {frame_end, word};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_enable <= 1'b1;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (ctrl_wr) ctrl_enable <= reg_wdata[0];
      if (ctrl_wr && reg_wdata[1]) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef PIXEL_OUT_STATS_EN
  logic [7:0] run_min;
  logic [7:0] run_max;
  logic [7:0] min_next;
  logic [7:0] max_next;

  always_comb begin
    min_next = (sat_pix < run_min) ? sat_pix : run_min;
    max_next = (sat_pix > run_max) ? sat_pix : run_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_min   <= '1;
      run_max   <= '0;
      last_min  <= '0;
      last_max  <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      if (at_frame_end) begin
        last_min  <= min_next;
        last_max  <= max_next;
        frame_cnt <= frame_cnt + 8'd1;
        run_min   <= '1;
        run_max   <= '0;
      end else begin
        run_min <= min_next;
        run_max <= max_next;
      end
    end
  end
`else
  always_comb begin
    frame_cnt = '0;
    last_min  = '0;
    last_max  = '0;
  end
`endif

  always_comb begin
    case (reg_addr)
      5'h10:   rdata_next = {7'h0, ctrl_enable};
      5'h11:   rdata_next = {5'h0, fifo_full, fifo_empty, overflow};
      5'h12:   rdata_next = drop_cnt;
      5'h13:   rdata_next = frame_cnt;
      5'h14:   rdata_next = last_min;
      5'h15:   rdata_next = last_max;
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) reg_rdata <= '0;
    else     reg_rdata <= rdata_next;
  end

endmodule

// File: tb/tb_pixel_out_stage.sv
// Directed and randomized bench for pixel_out_stage against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_pixel_out_stage;
  localparam int W = 32;
  localparam int H = 32;
  localparam int DEPTH = 16;
`ifdef PIXEL_OUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [31:0] in_pixel;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic               out_last;
  logic               reg_write_en;
  logic [4:0]         reg_addr;
  logic [7:0]         reg_wdata;
  logic [7:0]         reg_rdata;

  always #5 clk = ~clk;

  pixel_out_stage #(.IN_WIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .reg_write_en(reg_write_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents plus architectural register values.
  logic [32:0] q[$];
  bit          m_en, m_ovf;
  int          m_drop, m_lane, m_pix, m_min, m_max, m_lmin, m_lmax, m_fcnt;
  logic [31:0] m_word;
  int          n_out, n_last, n_vcyc;
  logic [31:0] last_word;
  logic        last_flag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 1; m_ovf = 0; m_drop = 0; m_lane = 0; m_pix = 0; m_word = '0;
    m_min = 255; m_max = 0; m_lmin = 0; m_lmax = 0; m_fcnt = 0;
  endtask

  function automatic logic [7:0] m_reg(input logic [4:0] a);
    case (a)
      5'h10: return {7'h0, m_en};
      5'h11: return {5'h0, q.size() == DEPTH, q.size() == 0, m_ovf};
      5'h12: return 8'(m_drop);
      5'h13: return STATS ? 8'(m_fcnt) : 8'h00;
      5'h14: return STATS ? 8'(m_lmin) : 8'h00;
      5'h15: return STATS ? 8'(m_lmax) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Evaluated mid-cycle: checks outputs, then advances the model to the state after the next edge.
  task automatic step();
    bit pop, fend;
    int px, b;
    if (rst) begin
      model_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      return;
    end
    if (out_valid) n_vcyc++;
    if (q.size() > 0) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, q[0][31:0]);
      chk("out_last", out_last, q[0][32]);
    end else begin
      chk("idle_valid", out_valid, 0);
    end
    pop = out_ready && (q.size() > 0);
    if (pop) begin
      n_out++;
      if (q[0][32]) n_last++;
      last_word = out_data;
      last_flag = out_last;
    end
    if (in_valid && m_en) begin
      px = in_pixel;
      b = (px < 0) ? 0 : (px > 255) ? 255 : px;
      m_word = m_word | (32'(b) << (8 * m_lane));
      if (b < m_min) m_min = b;
      if (b > m_max) m_max = b;
      fend = (m_pix == W * H - 1);
      if (m_lane == 3 || fend) begin
        if (q.size() == DEPTH && !pop) begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end else begin
          q.push_back({fend, m_word});
        end
        m_word = '0;
      end
      if (fend) begin
        m_lmin = m_min; m_lmax = m_max; m_fcnt = (m_fcnt + 1) % 256;
        m_min = 255; m_max = 0; m_lane = 0; m_pix = 0;
      end else begin
        m_lane = (m_lane + 1) % 4;
        m_pix++;
      end
    end
    if (reg_write_en && reg_addr == 5'h10) begin
      m_en = reg_wdata[0];
      if (reg_wdata[1]) begin m_ovf = 0; m_drop = 0; end
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_out = 0; n_last = 0; n_vcyc = 0; last_word = '0; last_flag = 1'b0;
    tick();
  endtask

  task automatic send(input int px);
    in_valid = 1'b1;
    in_pixel = px;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
    reg_write_en = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_write_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    reg_addr = a;
    tick();
    chk(tag, reg_rdata, exp);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64 && q.size() > 0; i++) tick();
    chk("drain_done", q.size(), 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    reg_write_en = 1'b0; reg_addr = '0; reg_wdata = '0;
    model_reset();
    reset_dut();
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_last", out_last, 0);
    chk("reset_rdata", reg_rdata, 0);
    rd_chk("reset_ctrl", 5'h10, 8'h01);
    rd_chk("reset_status", 5'h11, 8'h02);
    rd_chk("reset_unmapped", 5'h1F, 8'h00);

    // Saturation
    out_ready = 1'b1;
    send(-5); send(300); send(32'h7F); send(255);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_word", last_word, 32'hFF7FFF00);
    chk("sat_last", last_flag, 0);
    chk("sat_words", n_out, 1);
    chk("sat_valid_cycles", n_vcyc, 1);

    // Full frame
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < W * H; i++) send(i & 255);
    drain();
    chk("frame_words", n_out, 256);
    chk("frame_lasts", n_last, 1);
    chk("frame_last_word", last_word, 32'hFFFEFDFC);
    chk("frame_last_flag", last_flag, 1);
    rd_chk("frame_cnt", 5'h13, STATS ? 8'h01 : 8'h00);
    rd_chk("frame_min", 5'h14, 8'h00);
    rd_chk("frame_max", 5'h15, STATS ? 8'hFF : 8'h00);

    // Backpressure and overflow
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 68; i++) send(($urandom_range(255) + i) & 255);
    tick();
    rd_chk("ovf_status", 5'h11, 8'h05);
    rd_chk("ovf_drop", 5'h12, 8'h01);
    drain();
    chk("ovf_words", n_out, 16);
    rd_chk("ovf_status_drained", 5'h11, 8'h03);
    wr_reg(5'h10, 8'h03);
    rd_chk("clr_status", 5'h11, 8'h02);
    rd_chk("clr_drop", 5'h12, 8'h00);
    rd_chk("clr_ctrl", 5'h10, 8'h01);

    // Simultaneous push and pop while full
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 67; i++) send(i * 3);
    out_ready = 1'b1;
    send(77);
    drain();
    chk("pp_words", n_out, 17);
    rd_chk("pp_drop", 5'h12, 8'h00);
    rd_chk("pp_status", 5'h11, 8'h02);

    // Reset in the middle of a word
    reset_dut();
    out_ready = 1'b1;
    send(8'hAA); send(8'hBB);
    reset_dut();
    rd_chk("mid_ctrl", 5'h10, 8'h01);
    rd_chk("mid_status", 5'h11, 8'h02);
    rd_chk("mid_drop", 5'h12, 8'h00);
    rd_chk("mid_fcnt", 5'h13, 8'h00);
    rd_chk("mid_min", 5'h14, 8'h00);
    rd_chk("mid_max", 5'h15, 8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    drain();
    chk("mid_word", last_word, 32'h44332211);
    chk("mid_words", n_out, 1);

    // Disable
    wr_reg(5'h10, 8'h00);
    for (int i = 0; i < 8; i++) send(i + 1);
    for (int i = 0; i < 3; i++) tick();
    chk("dis_words", n_out, 1);
    rd_chk("dis_status", 5'h11, 8'h02);
    rd_chk("dis_ctrl", 5'h10, 8'h00);
    wr_reg(5'h10, 8'h01);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    drain();
    chk("en_words", n_out, 2);
    chk("en_word", last_word, 32'h08070605);

    // Randomized traffic across a frame boundary
    reset_dut();
    for (int i = 0; i < 2500; i++) begin
      in_valid = ($urandom % 2) != 0;
      in_pixel = $urandom_range(900) - 300;
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    in_valid = 1'b0;
    drain();
    for (int a = 16; a < 22; a++) rd_chk("rand_reg", 5'(a), m_reg(5'(a)));
    chk("rand_lasts", n_last, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
